function_memory: RTL and testbench

//  Memory-side responder for the function_expander fetch port (MEM_SEND_* / MEM_RECEIVE_*).
//  - Accepts read and write requests over a valid/ready handshake.
//  - Serves them from a word-organised synchronous RAM that holds function descriptors.
//  - Returns read data in request order through a valid/ready channel with a small response queue.
//  - Sits between function_expander (or an arbiter in front of several expanders) and the on-chip store.

---
 rtl/function_memory.sv | 125 ++++++++++++
 tb/tb_function_memory.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/function_memory.sv
// function_memory: descriptor store serving function_expander fetches.
// Requests arrive over a valid/ready handshake; reads return in order through
// a small response queue whose occupancy is bounded by a credit counter.
module function_memory #(
  parameter int    ADDR_BITS    = 10,
  parameter int    READ_LATENCY = 2,
  parameter int    QUEUE_DEPTH  = 4,
  parameter string INIT_FILE    = ""
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RECEIVE_ADDR_VALID,
  input  logic [31:0] RECEIVE_ADDR,
  input  logic        RECEIVE_DATA_VALID,
  input  logic [31:0] RECEIVE_DATA,
  output logic        RECEIVE_READY,
  output logic        SEND_VALID,
  output logic [31:0] SEND_DATA,
  input  logic        SEND_READY
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int PW    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW    = $clog2(QUEUE_DEPTH + 1);

  logic [31:0]          ram [DEPTH];
  logic [ADDR_BITS-1:0] idx;
  logic                 accept, rd_acc, wr_acc, pop;
  logic                 push;
  logic [31:0]          push_data;

  logic [31:0] fifo_q [QUEUE_DEPTH];
  logic [31:0] fifo_d [QUEUE_DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d, outstanding_q, outstanding_d;

  // Address bits outside the word index are intentionally ignored (wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{RECEIVE_ADDR[31:ADDR_BITS+2], RECEIVE_ADDR[1:0]};

  assign idx           = RECEIVE_ADDR[ADDR_BITS+1:2];
  assign RECEIVE_READY = !RST && (outstanding_q < CW'(QUEUE_DEPTH));
  assign accept        = RECEIVE_ADDR_VALID && RECEIVE_READY;
  assign wr_acc        = accept && RECEIVE_DATA_VALID;
  assign rd_acc        = accept && !RECEIVE_DATA_VALID;
  assign SEND_VALID    = (cnt_q != '0);
  assign SEND_DATA     = fifo_q[rp_q];
  assign pop           = SEND_VALID && SEND_READY;

  // RAM write port: the write lands at the accept edge, so any later read sees it.
  always_ff @(posedge CLK) begin
    if (wr_acc) ram[idx] <= RECEIVE_DATA;
  end

  if (READ_LATENCY == 1) begin : g_lat1
    assign push      = rd_acc;
    assign push_data = ram[idx];
  end else begin : g_pipe
    localparam int unsigned NS = READ_LATENCY - 1;
    logic [NS-1:0] pv_q, pv_d;
    logic [31:0]   pd_q [NS];
    logic [31:0]   pd_d [NS];

    // Read pipeline next state: stage 0 is the synchronous RAM read register.
    always_comb begin
      pv_d    = pv_q;
      pd_d    = pd_q;
      pv_d[0] = rd_acc;
      pd_d[0] = rd_acc ? ram[idx] : pd_q[0];
      for (int unsigned i = 1; i < NS; i++) begin
        pv_d[i] = pv_q[i-1];
        pd_d[i] = pd_q[i-1];
      end
    end

    // Pipeline valid bits clear on reset, dropping in-flight reads.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) pv_q <= '0;
      else     pv_q <= pv_d;
    end

    // Pipeline data carries no reset so stage 0 maps onto the RAM output register.
    always_ff @(posedge CLK) begin
      pd_q <= pd_d;
    end

    assign push      = pv_q[NS-1];
    assign push_data = pd_q[NS-1];
  end

  // Response queue and credit counter next state.
  always_comb begin
    fifo_d        = fifo_q;
    wp_d          = wp_q;
    rp_d          = rp_q;
    cnt_d         = cnt_q + CW'(push) - CW'(pop);
    outstanding_d = outstanding_q + CW'(rd_acc) - CW'(pop);
    if (push) begin
      fifo_d[wp_q] = push_data;
      wp_d         = wp_q + PW'(1);
    end
    if (pop) rp_d = rp_q + PW'(1);
  end

  // Queue and credit registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fifo_q        <= '{default: '0};
      wp_q          <= '0;
      rp_q          <= '0;
      cnt_q         <= '0;
      outstanding_q <= '0;
    end else begin
      fifo_q        <= fifo_d;
      wp_q          <= wp_d;
      rp_q          <= rp_d;
      cnt_q         <= cnt_d;
      outstanding_q <= outstanding_d;
    end
  end

  a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
    !(push && !pop && (cnt_q == CW'(QUEUE_DEPTH))));

endmodule

// File: tb/tb_function_memory.sv
module tb_function_memory;
  localparam int AB  = 10;
  localparam int LAT = 2;
  localparam int QD  = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RECEIVE_ADDR_VALID, RECEIVE_DATA_VALID, RECEIVE_READY;
  logic [31:0] RECEIVE_ADDR, RECEIVE_DATA;
  logic        SEND_VALID, SEND_READY;
  logic [31:0] SEND_DATA;

  always #5 CLK = ~CLK;

  function_memory #(.ADDR_BITS(AB), .READ_LATENCY(LAT), .QUEUE_DEPTH(QD), .INIT_FILE("")) dut (
    .CLK(CLK), .RST(RST),
    .RECEIVE_ADDR_VALID(RECEIVE_ADDR_VALID), .RECEIVE_ADDR(RECEIVE_ADDR),
    .RECEIVE_DATA_VALID(RECEIVE_DATA_VALID), .RECEIVE_DATA(RECEIVE_DATA),
    .RECEIVE_READY(RECEIVE_READY),
    .SEND_VALID(SEND_VALID), .SEND_DATA(SEND_DATA), .SEND_READY(SEND_READY)
  );

  int          n_cmp = 0, n_fail = 0;
  int          cyc_cnt = 0;
  logic [31:0] ref_mem [1 << AB];
  logic [31:0] exp_q [$];
  int          pop_cyc [$];
  bit          rand_rdy = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Word index as the address rule defines it: byte address / 4, modulo DEPTH.
  function automatic int widx(logic [31:0] a);
    return int'((a / 4) % (1 << AB));
  endfunction

  always @(posedge CLK) cyc_cnt++;

  // Random consumer backpressure during the random phase.
  always @(negedge CLK) if (rand_rdy) SEND_READY = ($urandom_range(0, 3) != 0);

  // Monitor: every response handshake is compared against the scoreboard head.
  always @(negedge CLK) begin
    #2;
    if (!RST && SEND_VALID && SEND_READY) begin
      pop_cyc.push_back(cyc_cnt);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_resp: got %h expected no response", SEND_DATA);
      end else begin
        check("resp_data", SEND_DATA, exp_q.pop_front());
      end
    end
  end

  task automatic req(input bit wr, input logic [31:0] a, input logic [31:0] d, output bit acc);
    @(negedge CLK);
    RECEIVE_ADDR_VALID = 1'b1;
    RECEIVE_ADDR       = a;
    RECEIVE_DATA_VALID = wr;
    RECEIVE_DATA       = d;
    #1;
    acc = RECEIVE_READY;
    if (acc) begin
      if (wr) ref_mem[widx(a)] = d;
      else    exp_q.push_back(ref_mem[widx(a)]);
    end
  endtask

  task automatic req_retry(input bit wr, input logic [31:0] a, input logic [31:0] d);
    bit acc = 0;
    int n = 0;
    while (!acc && n < 100) begin
      req(wr, a, d, acc);
      n++;
    end
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle();
    @(negedge CLK);
    RECEIVE_ADDR_VALID = 1'b0;
    RECEIVE_DATA_VALID = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    SEND_READY = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    repeat (4) @(negedge CLK);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit acc;
    int nacc, c;
    bit seen;
    logic [31:0] retry_a [$];

    // Reset with a request pending
    RST = 1'b1; RECEIVE_ADDR_VALID = 1'b1; RECEIVE_DATA_VALID = 1'b0;
    RECEIVE_ADDR = 32'h40; RECEIVE_DATA = '0; SEND_READY = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_ready", 32'(RECEIVE_READY), 32'd0);
    check("rst_valid", 32'(SEND_VALID), 32'd0);
    check("rst_data", SEND_DATA, 32'd0);
    @(negedge CLK);
    RECEIVE_ADDR_VALID = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    #1;
    check("rel_ready", 32'(RECEIVE_READY), 32'd1);

    // Preload a 64-word region with random content
    for (int w = 0; w < 64; w++) req_retry(1'b1, 32'(w * 4), $urandom);
    idle();

    // Write then read: latency and low-bit masking
    req_retry(1'b1, 32'h40, 32'hDEADBEEF);
    req(1'b0, 32'h40, 32'h0, acc);
    check("raw_accept", 32'(acc), 32'd1);
    c = 0; seen = 0;
    while (!seen && c < 20) begin
      @(posedge CLK);
      c++;
      #1;
      RECEIVE_ADDR_VALID = 1'b0;
      seen = SEND_VALID;
    end
    check("read_latency", 32'(c), 32'(LAT));
    check("raw_data", SEND_DATA, 32'hDEADBEEF);
    req_retry(1'b0, 32'h43, 32'h0);
    idle();
    drain();

    // Fetch burst: three back-to-back reads, consecutive responses
    req_retry(1'b1, 32'h100, 32'd1);
    req_retry(1'b1, 32'h104, 32'd2);
    req_retry(1'b1, 32'h108, 32'd3);
    idle();
    drain();
    pop_cyc.delete();
    req_retry(1'b0, 32'h100, 32'h0);
    req_retry(1'b0, 32'h104, 32'h0);
    req_retry(1'b0, 32'h108, 32'h0);
    idle();
    drain();
    check("burst_count", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() == 3) begin
      check("burst_gap1", 32'(pop_cyc[1] - pop_cyc[0]), 32'd1);
      check("burst_gap2", 32'(pop_cyc[2] - pop_cyc[1]), 32'd1);
    end

    // Backpressure: only QUEUE_DEPTH reads accepted, then retry the rest
    SEND_READY = 1'b0;
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      req(1'b0, 32'h100 + 32'(4 * (i % 3)), 32'h0, acc);
      if (acc) nacc++;
      else retry_a.push_back(32'h100 + 32'(4 * (i % 3)));
    end
    idle();
    #1;
    check("bp_accepted", 32'(nacc), 32'(QD));
    check("bp_ready_low", 32'(RECEIVE_READY), 32'd0);
    check("bp_send_valid", 32'(SEND_VALID), 32'd1);
    SEND_READY = 1'b1;
    foreach (retry_a[i]) req_retry(1'b0, retry_a[i], 32'h0);
    idle();
    drain();

    // Address wrap modulo DEPTH*4
    req_retry(1'b1, 32'h0, 32'h55);
    req_retry(1'b0, 32'h1000, 32'h0);
    idle();
    drain();
    check("wrap_model", ref_mem[0], 32'h55);

    // Random traffic with random backpressure
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      bit          wr;
      logic [31:0] a;
      wr = ($urandom_range(0, 2) == 0);
      a  = (32'($urandom_range(0, 15)) << 12) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      req_retry(wr, a, $urandom);
    end
    idle();
    rand_rdy = 0;
    drain();

    // Mid-run reset drops in-flight reads; RAM survives
    SEND_READY = 1'b0;
    for (int i = 0; i < 3; i++) req_retry(1'b0, 32'(i * 4), 32'h0);
    idle();
    @(negedge CLK);
    #3;
    RST = 1'b1;
    #1;
    check("midrst_valid", 32'(SEND_VALID), 32'd0);
    check("midrst_ready", 32'(RECEIVE_READY), 32'd0);
    exp_q.delete();
    @(negedge CLK);
    RST = 1'b0;
    SEND_READY = 1'b1;
    repeat (LAT + 2) @(negedge CLK);
    #1;
    check("post_rst_valid", 32'(SEND_VALID), 32'd0);
    check("post_rst_ready", 32'(RECEIVE_READY), 32'd1);
    for (int i = 0; i < 3; i++) req_retry(1'b0, 32'(i * 4), 32'h0);
    idle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
